// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : shared encodings for the MIPS fetch front end              |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_if : imem request/response and core-side instruction handshake   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic        addr_err;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, addr_err,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  npc_op, br_taken, imm16, imm26, rs_data
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, addr_err,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output npc_op, br_taken, imm16, imm26, rs_data
  );
endinterface
`default_nettype wire

// File: rtl/ifu_npc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npc : combinational next-PC select (seq / beq / j / jr)              |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic [31:0] npc,
  output logic        misalign
);

  logic [31:0] p4;
  logic [31:0] br_off;

  assign p4     = pc + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc = p4;
    case (npc_op)
      NPC_SEQ:    npc = p4;
      NPC_BRANCH: npc = br_taken ? (p4 + br_off) : p4;
      NPC_JUMP:   npc = {p4[31:28], imm26, 2'b00};
      default:    npc = {rs_data[31:2], 2'b00};
    endcase
  end

  // jr target low bits are dropped; flag it so the core can trap
  assign misalign = (npc_op == NPC_JR) && (rs_data[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu : PC register, imem fetch FSM and single-entry instruction hold  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ifu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  ifu_if.master            bus,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic [1:0]       state_q,    state_d;
  logic [31:0]      pc_q,       pc_d;
  logic [31:0]      instr_q,    instr_d;
  logic [31:0]      instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             addr_err_q, addr_err_d;
  logic [31:0]      npc_val;
  logic             npc_misalign;

  npc u_npc (
    .pc       (pc_q),
    .npc_op   (bus.npc_op),
    .br_taken (bus.br_taken),
    .imm16    (bus.imm16),
    .imm26    (bus.imm26),
    .rs_data  (bus.rs_data),
    .npc      (npc_val),
    .misalign (npc_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cnt_d      = cnt_q;
    addr_err_d = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (bus.imem_gnt) state_d = ST_WAIT;
      // only WAIT listens to rvalid, so grant-cycle and stray responses are dropped
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
          pc_d       = npc_val;
          cnt_d      = cnt_q + CNT_W'(1);
          addr_err_d = npc_misalign;
          state_d    = ST_FETCH;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign bus.addr_err    = addr_err_q;
  assign fetch_cnt       = cnt_q;

endmodule
`default_nettype wire

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit for the MIPS core; sits directly upstream of decode/execute and feeds it one instruction at a time.
- Owns the PC register and the next-PC logic: sequential, beq-style branch, j, jr.
- Talks to instruction memory over a request/grant + response-valid handshake, so variable-latency memories are supported.
- Delivers each instruction to the core with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  32  fetch address; equals pc.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction.
- instr_pc  out  32  PC of the held instruction.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  core consumes instruction this cycle.
- npc_op  in  2  next-PC select for the consumed instruction: 0=SEQ, 1=BRANCH, 2=JUMP, 3=JR.
- br_taken  in  1  branch condition; used only for BRANCH.
- imm16  in  16  branch offset.
- imm26  in  26  jump index.
- rs_data  in  32  jr target.
- addr_err  out  1  one-cycle pulse: misaligned jr target.
- fetch_cnt  out  CNT_W  instructions consumed since reset.

Behaviour:
- States: IDLE, FETCH, WAIT, HOLD.
- Reset (async, immediate) sets:
  - state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, fetch_cnt=0.
  - instr_valid=0, imem_req=0, addr_err=0.
- IDLE: always -> FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT; otherwise hold req and addr stable.
- WAIT:
  - imem_rvalid=1 -> instr<=imem_rdata, instr_pc<=pc, go to HOLD.
  - rvalid is never accepted in the grant cycle; earliest acceptance is the cycle after gnt.
- HOLD:
  - instr_valid=1.
  - instr_ready=1 -> pc<=npc, fetch_cnt<=fetch_cnt+1 (wraps modulo 2^CNT_W), go to FETCH.
  - instr_ready=0 -> hold everything stable.
- instr_valid is registered: high exactly while in HOLD.
- Minimum throughput: one instruction per 3 cycles (FETCH, WAIT, HOLD) with a zero-wait memory.
- npc (combinational from pc and the npc_* inputs; sampled only on the HOLD handshake); all sums mod 2^32:
  - p4 = pc+4.
  - SEQ: p4.
  - BRANCH: br_taken ? p4 + (sign_ext(imm16)<<2) : p4.
  - JUMP: {p4[31:28], imm26, 2'b00}.
  - JR: {rs_data[31:2], 2'b00}.
- addr_err:
  - Pulses one cycle, registered, on the HOLD handshake when npc_op=JR and rs_data[1:0]!=0.
  - PC still loads the forced-aligned target.
- Stray imem_rvalid in IDLE, FETCH or HOLD (e.g. a response to a request aborted by reset) is ignored.
- Reset during WAIT or HOLD:
  - Discards the pending instruction; instr_valid drops immediately.
  - Refetch starts from RESET_PC.
- npc_op, br_taken, imm16, imm26 and rs_data are don't-care outside the HOLD handshake cycle.

Decomposition:
- Shared package mips_pkg holds:
  - npc_op encodings (NPC_SEQ/BRANCH/JUMP/JR).
  - default RESET_PC.
  - the ifu state encoding.
- One sub-module, npc: purely combinational next-PC computation (inputs pc, npc_op, br_taken, imm16, imm26, rs_data; outputs npc, misalign).
- The FSM, PC register and counter stay in ifu.

Test Plan:
1. Reset, gnt=1 always, rvalid one cycle after gnt, instr_ready=1, npc_op=SEQ -> imem_addr sequence 0x3000, 0x3004, 0x3008; instr_valid every 3rd cycle; fetch_cnt=3 after third handshake.
2. At pc=0x3010: npc_op=BRANCH, br_taken=1, imm16=16'hFFFC -> next imem_addr=0x3004. Repeat with br_taken=0 -> 0x3014.
3. At pc=0x3000: npc_op=JUMP, imm26=26'h0000C10 -> next addr 0x0000_3040. Then npc_op=JR, rs_data=0x0000_3102 -> next addr 0x0000_3100, addr_err pulses exactly one cycle.
4. Backpressure: gnt low for 4 cycles, rvalid 3 cycles late, instr_ready low 5 cycles in HOLD -> imem_addr/instr/instr_pc stable throughout, no duplicate or skipped fetch, fetch_cnt increments once.
5. Assert rst mid-WAIT, then deliver a stray rvalid with 0xDEADBEEF after release -> instr_valid=0 immediately; stray data never appears on instr; first fetch after reset is at 0x3000.
6. Preload fetch_cnt path to 2^CNT_W-1 (CNT_W=4 override, 15 handshakes) -> 16th handshake wraps fetch_cnt to 0.
